fifo1_rd_drainer: RTL and testbench

Read-side consumer for the team's async FIFO, in the read clock domain. On a `start` command it pops exactly `len` words from the FIFO using its first-word-fall-through read port (`rdata`, `rempty`, `rinc`). It forwards those words on a valid/ready stream through an internal 2-entry buffer, so `rinc` never depends combinationally on downstream `m_ready`. It then pulses `done`.

---
 rtl/fifo1_rd_pkg.sv | 15 +
 rtl/fifo1_rd_skid.sv | 44 ++++
 rtl/fifo1_rd_drainer.sv | 113 +++++++++++
 tb/tb_fifo1_rd_drainer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo1_rd_pkg.sv
// Shared types and default sizes for the async-FIFO read-side drainer.
package fifo1_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    FLUSH = 2'd2,
    FIN   = 2'd3
  } rd_state_e;

  localparam int FIFO1_RD_DSIZE   = 8;
  localparam int FIFO1_RD_LW      = 8;
  localparam int FIFO1_RD_TIMEOUT = 255;

endpackage

// File: rtl/fifo1_rd_skid.sv
// Two-entry ring buffer between the FIFO pop and the output stream.
// The head entry is presented on dout; push and pop may happen together.
module fifo1_rd_skid
  import fifo1_rd_pkg::*;
#(
  parameter int DSIZE = FIFO1_RD_DSIZE
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             push,
  input  logic [DSIZE-1:0] din,
  input  logic             pop,
  output logic [DSIZE-1:0] dout,
  output logic [1:0]       buf_cnt
);

  logic [1:0][DSIZE-1:0] mem;
  logic                  wp, rp;

  assign dout = mem[rp];

  // Storage, pointers and occupancy; the caller never pushes when full
  // and never pops when empty.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      mem     <= '0;
      wp      <= 1'b0;
      rp      <= 1'b0;
      buf_cnt <= 2'd0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp      <= ~wp;
      end
      if (pop) rp <= ~rp;
      case ({push, pop})
        2'b10:   buf_cnt <= buf_cnt + 2'd1;
        2'b01:   buf_cnt <= buf_cnt - 2'd1;
        default: buf_cnt <= buf_cnt;
      endcase
    end
  end

endmodule

// File: rtl/fifo1_rd_drainer.sv
// Read-side drainer: on start, pops exactly len words from a FWFT async
// FIFO read port and forwards them on a valid/ready stream through a
// 2-entry buffer, then pulses done. rinc depends only on registered state
// and rempty, never on m_ready.
// Optional stall abort: define FIFO1_RD_TIMEOUT_EN to build the stall
// counter and the sticky timeout_err flag.
module fifo1_rd_drainer
  import fifo1_rd_pkg::*;
#(
  parameter int DSIZE   = FIFO1_RD_DSIZE,
  parameter int LW      = FIFO1_RD_LW,
  parameter int TIMEOUT = FIFO1_RD_TIMEOUT
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             start,
  input  logic [LW-1:0]    len,
  input  logic [DSIZE-1:0] rdata,
  input  logic             rempty,
  output logic             rinc,
  output logic [DSIZE-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             busy,
  output logic             done,
  output logic             timeout_err
);

  rd_state_e     state, state_nxt;
  logic [LW-1:0] remaining;
  logic [1:0]    buf_cnt;
  logic          start_acc, pop, stall_hit;

  assign start_acc = (state == IDLE) && start;
  assign pop       = m_valid && m_ready;
  assign rinc      = (state == XFER) && !rempty && (remaining != '0) && (buf_cnt != 2'd2);
  assign m_valid   = (buf_cnt != 2'd0);
  assign busy      = (state != IDLE);
  assign done      = (state == FIN);

  fifo1_rd_skid #(.DSIZE(DSIZE)) u_skid (
    .rclk    (rclk),
    .rrst_n  (rrst_n),
    .push    (rinc),
    .din     (rdata),
    .pop     (pop),
    .dout    (m_data),
    .buf_cnt (buf_cnt)
  );

  // State register.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next state; FLUSH looks ahead at the final handshake so done lands
  // in the cycle right after it.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = (len == '0) ? FIN : XFER;
      XFER:  if (stall_hit || (rinc && (remaining == LW'(1)))) state_nxt = FLUSH;
      FLUSH: if ((buf_cnt == 2'd0) || ((buf_cnt == 2'd1) && pop)) state_nxt = FIN;
      FIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Words still to pop; zeroed by a stall abort.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n)        remaining <= '0;
    else if (start_acc) remaining <= len;
    else if (stall_hit) remaining <= '0;
    else if (rinc)      remaining <= remaining - LW'(1);
  end

`ifdef FIFO1_RD_TIMEOUT_EN
  // Counter runs 0..TIMEOUT-1; the abort fires on the TIMEOUT-th stall cycle.
  localparam int SW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [SW-1:0] stall_cnt;
  logic          stalling, err_q;

  assign stalling    = (state == XFER) && (remaining != '0) && rempty;
  assign stall_hit   = stalling && (stall_cnt == SW'(TIMEOUT - 1));
  assign timeout_err = err_q;

  // Stall counter and sticky error, both cleared by an accepted start.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      stall_cnt <= '0;
      err_q     <= 1'b0;
    end else if (start_acc) begin
      stall_cnt <= '0;
      err_q     <= 1'b0;
    end else if (rinc) begin
      stall_cnt <= '0;
    end else if (stall_hit) begin
      stall_cnt <= '0;
      err_q     <= 1'b1;
    end else if (stalling) begin
      stall_cnt <= stall_cnt + SW'(1);
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign stall_hit      = 1'b0;
  assign timeout_err    = 1'b0;
`endif

endmodule

// File: tb/tb_fifo1_rd_drainer.sv
// Directed bench for fifo1_rd_drainer with a small FWFT FIFO model.
module tb_fifo1_rd_drainer;

`ifdef FIFO1_RD_TIMEOUT_EN
  localparam int GAP = 12;
`else
  localparam int GAP = 20;
`endif

  logic       rclk = 1'b0;
  logic       rrst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] len = '0;
  logic [7:0] rdata;
  logic       rempty;
  logic       rinc;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic       busy, done, timeout_err;

  int total = 0;
  int bad   = 0;

  // FIFO model: head word visible whenever not empty; pops at posedge.
  logic [7:0] fmem [0:63];
  logic [6:0] wptr = '0;
  logic [6:0] rptr = '0;
  logic [6:0] base;
  logic [7:0] rx [$];

  assign rdata  = fmem[rptr[5:0]];
  assign rempty = (wptr == rptr);

  always #5 rclk = ~rclk;

  always @(posedge rclk) begin
    if (rinc) rptr <= rptr + 7'd1;
    if (rrst_n && m_valid && m_ready) rx.push_back(m_data);
  end

  fifo1_rd_drainer #(.DSIZE(8), .LW(8), .TIMEOUT(16)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .start(start), .len(len),
    .rdata(rdata), .rempty(rempty), .rinc(rinc),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  task automatic push_word(input logic [7:0] d);
    fmem[wptr[5:0]] = d;
    wptr = wptr + 7'd1;
  endtask

  // Pulse start for one edge; returns in the cycle after acceptance.
  task automatic issue(input logic [7:0] l);
    start = 1'b1;
    len   = l;
    @(negedge rclk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int c;
    c = 0;
    while (done !== 1'b1 && c < bound) begin
      @(negedge rclk);
      c++;
    end
  endtask

  task automatic test_reset;
    rrst_n = 1'b0;
    repeat (2) @(negedge rclk);
    total++; if ({rinc, m_valid, busy, done, timeout_err} !== 5'b0) begin
      bad++; $display("FAIL reset_ctl got=%b want=00000", {rinc, m_valid, busy, done, timeout_err});
    end
    total++; if (m_data !== 8'h00) begin
      bad++; $display("FAIL reset_mdata got=%h want=00", m_data);
    end
    rrst_n = 1'b1;
    @(negedge rclk);
  endtask

  task automatic test_stream;
    logic [7:0] rv, mv, dv, bv, d2;
    logic [7:0] exp_d [4];
    exp_d = '{8'h11, 8'h12, 8'h13, 8'h14};
    rx.delete(); base = rptr;
    for (int i = 0; i < 4; i++) push_word(exp_d[i]);
    m_ready = 1'b1;
    @(negedge rclk);
    issue(8'd4);
    d2 = '0;
    for (int k = 0; k < 8; k++) begin
      rv[k] = rinc; mv[k] = m_valid; dv[k] = done; bv[k] = busy;
      if (k == 1) d2 = m_data;
      if (k < 7) @(negedge rclk);
    end
    total++; if (rv !== 8'h0F) begin bad++; $display("FAIL stream_rinc got=%b want=00001111", rv); end
    total++; if (mv !== 8'h1E) begin bad++; $display("FAIL stream_valid got=%b want=00011110", mv); end
    total++; if (dv !== 8'h20) begin bad++; $display("FAIL stream_done got=%b want=00100000", dv); end
    total++; if (bv !== 8'h3F) begin bad++; $display("FAIL stream_busy got=%b want=00111111", bv); end
    total++; if (d2 !== 8'h11) begin bad++; $display("FAIL stream_first got=%h want=11", d2); end
    total++; if (rx.size() != 4) begin bad++; $display("FAIL stream_count got=%0d want=4", rx.size()); end
    else for (int i = 0; i < 4; i++) begin
      total++; if (rx[i] !== exp_d[i]) begin bad++; $display("FAIL stream_word%0d got=%h want=%h", i, rx[i], exp_d[i]); end
    end
  endtask

  task automatic test_backpressure;
    rx.delete(); base = rptr;
    push_word(8'h21); push_word(8'h22); push_word(8'h23);
    m_ready = 1'b0;
    @(negedge rclk);
    issue(8'd3);
    repeat (2) @(negedge rclk);
    total++; if ({rinc, m_valid} !== 2'b01) begin bad++; $display("FAIL bp_full got rinc,valid=%b want=01", {rinc, m_valid}); end
    total++; if (m_data !== 8'h21) begin bad++; $display("FAIL bp_head got=%h want=21", m_data); end
    repeat (7) @(negedge rclk);
    total++; if (rptr - base !== 7'd2) begin bad++; $display("FAIL bp_pops got=%0d want=2", rptr - base); end
    total++; if (m_data !== 8'h21) begin bad++; $display("FAIL bp_stable got=%h want=21", m_data); end
    m_ready = 1'b1;
    wait_done(20);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL bp_done got=%b want=1", done); end
    total++; if (rx.size() != 3 || rx[0] !== 8'h21 || rx[1] !== 8'h22 || rx[2] !== 8'h23) begin
      bad++; $display("FAIL bp_data got=%p want=21,22,23", rx);
    end
    @(negedge rclk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_busy_fall got=%b want=0", busy); end
  endtask

  task automatic test_underflow;
    rx.delete(); base = rptr;
    push_word(8'h31);
    m_ready = 1'b1;
    @(negedge rclk);
    issue(8'd2);
    repeat (GAP) @(negedge rclk);
    total++; if ({busy, rinc, m_valid, done} !== 4'b1000) begin
      bad++; $display("FAIL uf_wait got busy,rinc,valid,done=%b want=1000", {busy, rinc, m_valid, done});
    end
    total++; if (rptr - base !== 7'd1) begin bad++; $display("FAIL uf_pops got=%0d want=1", rptr - base); end
    push_word(8'h32);
    #1;
    total++; if (rinc !== 1'b1) begin bad++; $display("FAIL uf_resume got=%b want=1", rinc); end
    wait_done(10);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL uf_done got=%b want=1", done); end
    total++; if (rx.size() != 2 || rx[0] !== 8'h31 || rx[1] !== 8'h32) begin
      bad++; $display("FAIL uf_data got=%p want=31,32", rx);
    end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL uf_terr got=%b want=0", timeout_err); end
    @(negedge rclk);
  endtask

  task automatic test_len_zero;
    base = rptr;
    push_word(8'h41);
    @(negedge rclk);
    start = 1'b1; len = 8'd0;
    @(negedge rclk);
    total++; if ({done, busy, rinc} !== 3'b110) begin
      bad++; $display("FAIL lz_done got done,busy,rinc=%b want=110", {done, busy, rinc});
    end
    len = 8'd1;                     // start still high while busy: must be ignored
    @(negedge rclk);
    start = 1'b0;
    total++; if ({done, busy, rinc} !== 3'b000) begin
      bad++; $display("FAIL lz_ignore got done,busy,rinc=%b want=000", {done, busy, rinc});
    end
    repeat (3) @(negedge rclk);
    total++; if (rptr - base !== 7'd0 || busy !== 1'b0) begin
      bad++; $display("FAIL lz_nopop got pops=%0d busy=%b want pops=0 busy=0", rptr - base, busy);
    end
  endtask

  task automatic test_reset_mid;
    base = rptr;                    // 0x41 is still at the FIFO head
    push_word(8'h42); push_word(8'h43);
    m_ready = 1'b0;
    @(negedge rclk);
    issue(8'd3);
    @(negedge rclk);
    total++; if (m_valid !== 1'b1 || m_data !== 8'h41) begin
      bad++; $display("FAIL rm_pre got valid=%b data=%h want valid=1 data=41", m_valid, m_data);
    end
    rrst_n = 1'b0;
    #1;
    total++; if ({rinc, m_valid, busy, done, timeout_err} !== 5'b0 || m_data !== 8'h00) begin
      bad++; $display("FAIL rm_async got=%b data=%h want=00000 data=00", {rinc, m_valid, busy, done, timeout_err}, m_data);
    end
    @(negedge rclk);
    rrst_n = 1'b1;
    total++; if (rptr - base !== 7'd1) begin bad++; $display("FAIL rm_lost got=%0d want=1", rptr - base); end
    @(negedge rclk);
    rx.delete();
    m_ready = 1'b1;
    issue(8'd2);
    total++; if ({busy, rinc, m_valid} !== 3'b110) begin
      bad++; $display("FAIL rm_restart got busy,rinc,valid=%b want=110", {busy, rinc, m_valid});
    end
    @(negedge rclk);
    total++; if (m_valid !== 1'b1 || m_data !== 8'h42) begin
      bad++; $display("FAIL rm_first got valid=%b data=%h want valid=1 data=42", m_valid, m_data);
    end
    wait_done(10);
    total++; if (done !== 1'b1 || rx.size() != 2 || rx[0] !== 8'h42 || rx[1] !== 8'h43) begin
      bad++; $display("FAIL rm_data got done=%b rx=%p want done=1 rx=42,43", done, rx);
    end
    @(negedge rclk);
  endtask

`ifdef FIFO1_RD_TIMEOUT_EN
  task automatic test_timeout;
    rx.delete();
    m_ready = 1'b1;
    @(negedge rclk);
    total++; if (rempty !== 1'b1) begin bad++; $display("FAIL to_empty got=%b want=1", rempty); end
    issue(8'd5);
    repeat (15) @(negedge rclk);
    total++; if ({busy, timeout_err} !== 2'b10) begin
      bad++; $display("FAIL to_before got busy,terr=%b want=10", {busy, timeout_err});
    end
    @(negedge rclk);
    total++; if ({timeout_err, done} !== 2'b10) begin
      bad++; $display("FAIL to_set got terr,done=%b want=10", {timeout_err, done});
    end
    @(negedge rclk);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL to_done got=%b want=1", done); end
    @(negedge rclk);
    total++; if ({busy, timeout_err} !== 2'b01) begin
      bad++; $display("FAIL to_sticky got busy,terr=%b want=01", {busy, timeout_err});
    end
    issue(8'd0);
    total++; if ({timeout_err, done} !== 2'b01) begin
      bad++; $display("FAIL to_clear got terr,done=%b want=01", {timeout_err, done});
    end
    @(negedge rclk);
  endtask
`endif

  initial begin
    @(negedge rclk);
    test_reset;
    test_stream;
    test_backpressure;
    test_underflow;
    test_len_zero;
    test_reset_mid;
`ifdef FIFO1_RD_TIMEOUT_EN
    test_timeout;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
